// File: rtl/frac_div_ctrl.sv
// rtl/frac_div_ctrl.sv - fractional clock-enable generator with period-aligned ratio reconfiguration
module frac_div_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_num,
    input  logic [W-1:0] cfg_den,
    output logic         cfg_ready,
    output logic         tick,
    output logic         busy,
    output logic         err,
    output logic [W-1:0] phase
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t       r_state, w_state_nx;
    logic [W-1:0] r_acc, w_acc_nx;
    logic [W-1:0] r_cnt, w_cnt_nx;
    logic [W-1:0] r_num, w_num_nx;
    logic [W-1:0] r_den, w_den_nx;
    logic [W-1:0] r_sh_num, w_sh_num_nx;
    logic [W-1:0] r_sh_den, w_sh_den_nx;
    logic         r_loaded, w_loaded_nx;
    logic         r_tick, w_tick_nx;
    logic         r_err, w_err_nx;

    logic [W:0]   w_sum;
    logic         w_hit;
    logic [W-1:0] w_acc_step;
    logic         w_period_end;
    logic [W-1:0] w_cnt_step;
    logic         w_cfg_take;
    logic         w_cfg_ok;

    // A pending shadow ratio blocks further offers until it is committed.
    assign cfg_ready = (r_state != S_PEND);
    assign busy      = (r_state != S_IDLE);
    assign phase     = r_cnt;
    assign tick      = r_tick;
    assign err       = r_err;

    assign w_cfg_take = cfg_valid && cfg_ready;
    assign w_cfg_ok   = (cfg_num != '0) && (cfg_num <= cfg_den);

    // One accumulator step under the active ratio; the sum is one bit wider so it cannot wrap.
    always_comb begin
        w_sum        = {1'b0, r_acc} + {1'b0, r_num};
        w_hit        = (w_sum >= {1'b0, r_den});
        w_acc_step   = w_hit ? W'(w_sum - {1'b0, r_den}) : w_sum[W-1:0];
        w_period_end = (r_cnt == (r_den - 1'b1));
        w_cnt_step   = w_period_end ? '0 : (r_cnt + 1'b1);
    end

    // Next-state and datapath decisions; everything holds unless a branch says otherwise.
    always_comb begin
        w_state_nx  = r_state;
        w_acc_nx    = r_acc;
        w_cnt_nx    = r_cnt;
        w_num_nx    = r_num;
        w_den_nx    = r_den;
        w_sh_num_nx = r_sh_num;
        w_sh_den_nx = r_sh_den;
        w_loaded_nx = r_loaded;
        w_tick_nx   = 1'b0;
        w_err_nx    = w_cfg_take && !w_cfg_ok;

        case (r_state)
            S_IDLE: begin
                // A config on the same edge as en wins; RUN starts one edge later.
                if (w_cfg_take && w_cfg_ok) begin
                    w_num_nx    = cfg_num;
                    w_den_nx    = cfg_den;
                    w_loaded_nx = 1'b1;
                end else if (en && r_loaded) begin
                    w_state_nx = S_RUN;
                    w_acc_nx   = '0;
                    w_cnt_nx   = '0;
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_state_nx = S_IDLE;
                    w_acc_nx   = '0;
                    w_cnt_nx   = '0;
                    // A ratio offered while stopping goes straight to active.
                    if (w_cfg_take && w_cfg_ok) begin
                        w_num_nx = cfg_num;
                        w_den_nx = cfg_den;
                    end
                end else begin
                    w_tick_nx = w_hit;
                    w_acc_nx  = w_acc_step;
                    w_cnt_nx  = w_cnt_step;
                    if (w_cfg_take && w_cfg_ok) begin
                        w_sh_num_nx = cfg_num;
                        w_sh_den_nx = cfg_den;
                        w_state_nx  = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (!en) begin
                    // Stop immediately but keep the waiting ratio.
                    w_state_nx = S_IDLE;
                    w_acc_nx   = '0;
                    w_cnt_nx   = '0;
                    w_num_nx   = r_sh_num;
                    w_den_nx   = r_sh_den;
                end else begin
                    w_tick_nx = w_hit;
                    if (w_period_end) begin
                        w_num_nx   = r_sh_num;
                        w_den_nx   = r_sh_den;
                        w_acc_nx   = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = S_RUN;
                    end else begin
                        w_acc_nx = w_acc_step;
                        w_cnt_nx = w_cnt_step;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_acc_nx   = '0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_num    <= '0;
            r_den    <= '0;
            r_sh_num <= '0;
            r_sh_den <= '0;
            r_loaded <= 1'b0;
            r_tick   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_acc    <= w_acc_nx;
            r_cnt    <= w_cnt_nx;
            r_num    <= w_num_nx;
            r_den    <= w_den_nx;
            r_sh_num <= w_sh_num_nx;
            r_sh_den <= w_sh_den_nx;
            r_loaded <= w_loaded_nx;
            r_tick   <= w_tick_nx;
            r_err    <= w_err_nx;
        end
    end

endmodule
